// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared definitions for the iterative RV32M divider.
//   - DIV_* operation codes driven on div_unit.op by the decoder
//     (funct3 100..111 with funct7 = 0000001).
//   - Small helpers for decoding the operation code.
package div_unit_pkg;

  localparam logic [1:0] DIV_DIV  = 2'd0;
  localparam logic [1:0] DIV_DIVU = 2'd1;
  localparam logic [1:0] DIV_REM  = 2'd2;
  localparam logic [1:0] DIV_REMU = 2'd3;

  // Even codes are the signed variants.
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  // Upper code bit selects remainder over quotient.
  function automatic logic op_is_rem(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/div_unit_step.sv
// div_unit_step: one combinational restoring-division step.
// Ports:
//   rem_i [XLEN-1:0]  current partial remainder (always < divisor)
//   q_i   [XLEN-1:0]  dividend/quotient shift register
//   d_i   [XLEN-1:0]  divisor magnitude
//   rem_o [XLEN-1:0]  next partial remainder
//   q_o   [XLEN-1:0]  next quotient shift register (new bit in LSB)
module div_unit_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] q_i,
  input  logic [XLEN-1:0] d_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] q_o
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] trial;
  logic          fits;

  // The trial subtract is one bit wider so its MSB is the borrow/sign.
  assign shifted = {rem_i, q_i[XLEN-1]};
  assign trial   = shifted - {1'b0, d_i};
  assign fits    = ~trial[XLEN];

  // On a fit the result is < d, so the top bit of trial is zero; on a miss the
  // shifted value is < d as well. Either way XLEN bits hold the remainder.
  assign rem_o = fits ? trial[XLEN-1:0] : shifted[XLEN-1:0];
  assign q_o   = {q_i[XLEN-2:0], fits};

endmodule

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 divider for DIV/DIVU/REM/REMU.
// One restoring step per clock; busy stalls the pipeline while it runs.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start           launch request, accepted only in IDLE without flush
//   op [1:0]        DIV_DIV / DIV_DIVU / DIV_REM / DIV_REMU
//   a, b [XLEN-1:0] dividend, divisor (latched on acceptance)
//   flush           abort; wins over start, no done for the aborted op
//   busy            operation in progress (accept edge through done edge)
//   done            one-cycle pulse, result valid
//   result          quotient or remainder, held until the next completion
// Handshake: start is a request sampled only while IDLE; there is no
// backpressure on done, which is a single-cycle strobe with result valid.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] ONE     = XLEN'(1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

  function automatic logic [XLEN-1:0] neg(input logic [XLEN-1:0] x);
    return ~x + ONE;
  endfunction

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] q_q;
  logic [XLEN-1:0] d_q;
  logic            neg_quo_q;
  logic            neg_rem_q;
  logic            is_rem_q;
  logic            busy_q;
  logic            done_q;
  logic [XLEN-1:0] result_q;

  logic [XLEN-1:0] rem_d;
  logic [XLEN-1:0] q_d;

  // Operand preparation for the accept edge.
  logic            sgn;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_abs;
  logic [XLEN-1:0] b_abs;
  logic            div_zero;
  logic            overflow;

  assign sgn      = op_is_signed(op);
  assign a_neg    = sgn & a[XLEN-1];
  assign b_neg    = sgn & b[XLEN-1];
  // |MIN_NEG| wraps to MIN_NEG, which is the right magnitude read unsigned.
  assign a_abs    = a_neg ? neg(a) : a;
  assign b_abs    = b_neg ? neg(b) : b;
  assign div_zero = (b == '0);
  assign overflow = sgn && (a == MIN_NEG) && (b == '1);

  div_unit_step #(.XLEN(XLEN)) u_step (
    .rem_i (rem_q),
    .q_i   (q_q),
    .d_i   (d_q),
    .rem_o (rem_d),
    .q_o   (q_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      q_q       <= '0;
      d_q       <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      is_rem_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (flush) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (start) begin
              busy_q   <= 1'b1;
              is_rem_q <= op_is_rem(op);
              cnt_q    <= CW'(XLEN);
              d_q      <= b_abs;
              // Special cases preload the final answer and skip CALC; the
              // sign flags are cleared so FIX passes the values through.
              if (div_zero) begin
                q_q       <= '1;
                rem_q     <= a;
                neg_quo_q <= 1'b0;
                neg_rem_q <= 1'b0;
                state_q   <= FIX;
              end else if (overflow) begin
                q_q       <= MIN_NEG;
                rem_q     <= '0;
                neg_quo_q <= 1'b0;
                neg_rem_q <= 1'b0;
                state_q   <= FIX;
              end else begin
                q_q       <= a_abs;
                rem_q     <= '0;
                neg_quo_q <= a_neg ^ b_neg;
                neg_rem_q <= a_neg;
                state_q   <= CALC;
              end
            end
          end
          CALC: begin
            rem_q <= rem_d;
            q_q   <= q_d;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
              state_q <= FIX;
            end
          end
          FIX: begin
            if (is_rem_q) begin
              result_q <= neg_rem_q ? neg(rem_q) : rem_q;
            end else begin
              result_q <= neg_quo_q ? neg(q_q) : q_q;
            end
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;
  import div_unit_pkg::*;

  // ---------------------------------------------------------------- clock/reset
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;

  always #5 clk = ~clk;

  div_unit #(.XLEN(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  int          tests = 0;
  int          fails = 0;
  int          edges = 0;
  logic [31:0] last_exp = 32'h0;

  // ---------------------------------------------------------------- checking
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: RISC-V M-extension rules in plain integer arithmetic.
  function automatic logic [31:0] ref_res(input logic [1:0] o, input logic [31:0] x,
                                          input logic [31:0] y);
    int sx;
    int sy;
    logic ovf;
    sx  = x;
    sy  = y;
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    case (o)
      DIV_DIV:  return (y == 0) ? 32'hFFFF_FFFF : ovf ? x : 32'(sx / sy);
      DIV_DIVU: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      DIV_REM:  return (y == 0) ? x : ovf ? 32'h0 : 32'(sx % sy);
      default:  return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic int ref_lat(input logic [1:0] o, input logic [31:0] x,
                                 input logic [31:0] y);
    logic signed_op;
    signed_op = (o == DIV_DIV) || (o == DIV_REM);
    if (y == 0) return 1;
    if (signed_op && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // ---------------------------------------------------------------- drivers
  task automatic step();
    @(posedge clk);
    #1;
    edges++;
  endtask

  // Drives start for one cycle; returns just after E0, then scrambles inputs.
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    edges = 0;
    start = 1'b0;
    op    = 2'($urandom_range(0, 3));
    a     = $urandom;
    b     = $urandom;
  endtask

  task automatic wait_done(input string tag, input logic [31:0] exp, input int lat);
    logic busy_ok;
    busy_ok = 1'b1;
    while (done !== 1'b1 && edges < 100) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      step();
    end
    chk({tag, "_done"},   {31'b0, done},    32'd1);
    chk({tag, "_lat"},    32'(edges),       32'(lat));
    chk({tag, "_result"}, result,           exp);
    chk({tag, "_idle"},   {31'b0, busy},    32'd0);
    chk({tag, "_busy"},   {31'b0, busy_ok}, 32'd1);
    last_exp = exp;
  endtask

  task automatic run(input string tag, input logic [1:0] o, input logic [31:0] x,
                     input logic [31:0] y, input logic [31:0] exp, input int lat);
    issue(o, x, y);
    chk({tag, "_e0busy"}, {31'b0, busy}, 32'd1);
    chk({tag, "_e0done"}, {31'b0, done}, 32'd0);
    wait_done(tag, exp, lat);
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    logic        seen_done;
    logic [1:0]  o;
    logic [31:0] x;
    logic [31:0] y;

    rst_n = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    op    = DIV_DIV;
    a     = '0;
    b     = '0;
    #3 rst_n = 1'b0;
    #1;
    chk("rst_busy",   {31'b0, busy}, 32'd0);
    chk("rst_done",   {31'b0, done}, 32'd0);
    chk("rst_result", result,        32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Directed vectors; consecutive runs start on the done cycle (back-to-back).
    run("div_m7_2",   DIV_DIV,  32'hFFFF_FFF9, 32'd2,  32'hFFFF_FFFD, 33);
    run("rem_m7_2",   DIV_REM,  32'hFFFF_FFF9, 32'd2,  32'hFFFF_FFFF, 33);
    run("divu_100_7", DIV_DIVU, 32'd100,       32'd7,  32'd14,        33);
    run("remu_100_7", DIV_REMU, 32'd100,       32'd7,  32'd2,         33);
    run("remu_big",   DIV_REMU, 32'hFFFF_FFFF, 32'h10, 32'hF,         33);
    run("divu_by0",   DIV_DIVU, 32'd5,         32'd0,  32'hFFFF_FFFF, 1);
    run("rem_by0",    DIV_REM,  32'd5,         32'd0,  32'd5,         1);
    run("div_ovf",    DIV_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run("rem_ovf",    DIV_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0,  1);
    run("div_min_2",  DIV_DIV,  32'h8000_0000, 32'd2,  32'hC000_0000, 33);

    // Flush mid-calculation: abort, no done, result unchanged.
    issue(DIV_DIVU, 32'hDEAD_BEEF, 32'd3);
    repeat (10) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_busy",   {31'b0, busy}, 32'd0);
    chk("flush_done",   {31'b0, done}, 32'd0);
    chk("flush_result", result,        last_exp);
    seen_done = 1'b0;
    repeat (40) begin
      if (done === 1'b1) seen_done = 1'b1;
      step();
    end
    chk("flush_nodone", {31'b0, seen_done}, 32'd0);
    chk("flush_hold",   result,             last_exp);
    run("after_flush", DIV_DIVU, 32'd9, 32'd3, 32'd3, 33);

    // start pulsed while busy is ignored.
    issue(DIV_DIVU, 32'd100, 32'd7);
    repeat (5) step();
    start = 1'b1;
    op    = DIV_DIV;
    a     = 32'd1;
    b     = 32'd0;
    step();
    start = 1'b0;
    wait_done("ignore_start", 32'd14, 33);

    // flush in IDLE drops a simultaneous start.
    flush = 1'b1;
    start = 1'b1;
    op    = DIV_DIVU;
    a     = 32'd8;
    b     = 32'd0;
    step();
    flush = 1'b0;
    start = 1'b0;
    chk("idle_flush_busy", {31'b0, busy}, 32'd0);
    step();
    chk("idle_flush_done", {31'b0, done}, 32'd0);
    chk("idle_flush_res",  result,        last_exp);

    // Asynchronous reset mid-CALC.
    issue(DIV_DIVU, 32'd100, 32'd7);
    repeat (5) step();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy",   {31'b0, busy}, 32'd0);
    chk("mid_rst_done",   {31'b0, done}, 32'd0);
    chk("mid_rst_result", result,        32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Randomized operations, back-to-back, against the reference model.
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 7))
        0: y = 32'd0;
        1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        2: y = 32'($urandom_range(1, 15));
        3: y = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        default: ;
      endcase
      run($sformatf("rnd%0d", i), o, x, y, ref_res(o, x, y), ref_lat(o, x, y));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
